// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - per-pin synchronizer, debounce counter and edge pulse generator
module gpio_input_conditioner #(
    parameter int NUM_PINS = 8,
    parameter int DB_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [NUM_PINS-1:0] pin_in,
    input  logic [DB_WIDTH-1:0] db_limit,
    output logic [NUM_PINS-1:0] r_data,
    output logic [NUM_PINS-1:0] rise,
    output logic [NUM_PINS-1:0] fall
);

    logic [NUM_PINS-1:0]               s1;
    logic [NUM_PINS-1:0]               s2;
    logic [NUM_PINS-1:0]               q;
    logic [NUM_PINS-1:0]               q_next;
    logic [NUM_PINS-1:0][DB_WIDTH-1:0] cnt;
    logic [NUM_PINS-1:0][DB_WIDTH-1:0] cnt_next;
    logic [DB_WIDTH:0]                 limit_ext;
    logic                              short_window;

    assign limit_ext    = {1'b0, db_limit};
    assign short_window = (db_limit <= DB_WIDTH'(1));

    // Compare against the extended limit so cnt+1 cannot wrap even after db_limit is lowered.
    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (s2[i] == q[i]) begin
                cnt_next[i] = '0;
            end else if (short_window ||
                         (({1'b0, cnt[i]} + (DB_WIDTH+1)'(1)) >= limit_ext)) begin
                q_next[i]   = s2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + DB_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s1   <= '0;
            s2   <= '0;
            q    <= '0;
            cnt  <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            s1   <= pin_in;
            s2   <= s1;
            q    <= q_next;
            cnt  <= cnt_next;
            rise <= q_next & ~q;
            fall <= ~q_next & q;
        end
    end

    assign r_data = q;

endmodule
